wishbone_initiator: RTL

Single-outstanding-transaction Wishbone classic-cycle bus master that drives the device core's 30-bit word-addressed, 32-bit Wishbone slave port from a simple valid/ready command stream. It serves simulation benches and on-chip soft logic that access the USB core's CSRs and endpoint buffers. A bus timeout aborts the cycle if the slave never answers. It generates every signal the slave port consumes: adr, dat_w, sel, cyc, stb, we, cti, bte. It consumes dat_r, ack and err.

---
 rtl/wishbone_initiator_if.sv | 29 ++
 rtl/wishbone_initiator.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/wishbone_initiator_if.sv
// Wishbone classic-cycle bus between the initiator and the device core's
// 30-bit word-addressed, 32-bit slave port.
interface wishbone_initiator_if;
  localparam int unsigned ADR_W = 30;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;

  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] dat_w;
  logic [DAT_W-1:0] dat_r;
  logic [SEL_W-1:0] sel;
  logic             we;
  logic             cyc;
  logic             stb;
  logic [2:0]       cti;
  logic [1:0]       bte;
  logic             ack;
  logic             err;

  modport master (
    output adr, dat_w, sel, we, cyc, stb, cti, bte,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb, cti, bte,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wishbone_initiator.sv
// Single-outstanding Wishbone classic-cycle master fed by a valid/ready
// command stream, with a bus timeout that aborts cycles nobody answers.
module wishbone_initiator #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clk48,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [29:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        rsp_timeout,
  wishbone_initiator_if.master wb
);

  localparam int unsigned ADR_W = 30;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;
  // Last counter value before abort; unused when the timeout is disabled.
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [ADR_W-1:0] r_adr, w_adr;
  logic [DAT_W-1:0] r_dat_w, w_dat_w;
  logic [SEL_W-1:0] r_sel, w_sel;
  logic             r_we, w_we;
  logic             r_cyc, w_cyc;
  logic             r_stb, w_stb;
  logic             r_cmd_ready, w_cmd_ready;
  logic             r_rsp_valid, w_rsp_valid;
  logic [DAT_W-1:0] r_rsp_dat, w_rsp_dat;
  logic             r_rsp_err, w_rsp_err;
  logic             r_rsp_timeout, w_rsp_timeout;

  // State and every output register; reset drops cyc/stb asynchronously.
  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_adr         <= '0;
      r_dat_w       <= '0;
      r_sel         <= '0;
      r_we          <= 1'b0;
      r_cyc         <= 1'b0;
      r_stb         <= 1'b0;
      r_cmd_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_dat     <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_adr         <= w_adr;
      r_dat_w       <= w_dat_w;
      r_sel         <= w_sel;
      r_we          <= w_we;
      r_cyc         <= w_cyc;
      r_stb         <= w_stb;
      r_cmd_ready   <= w_cmd_ready;
      r_rsp_valid   <= w_rsp_valid;
      r_rsp_dat     <= w_rsp_dat;
      r_rsp_err     <= w_rsp_err;
      r_rsp_timeout <= w_rsp_timeout;
    end
  end

  // Next state and next register values.
  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_adr         = r_adr;
    w_dat_w       = r_dat_w;
    w_sel         = r_sel;
    w_we          = r_we;
    w_cyc         = r_cyc;
    w_stb         = r_stb;
    w_rsp_valid   = r_rsp_valid;
    w_rsp_dat     = r_rsp_dat;
    w_rsp_err     = r_rsp_err;
    w_rsp_timeout = r_rsp_timeout;

    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_adr   = cmd_adr;
          w_dat_w = cmd_dat;
          w_sel   = cmd_sel;
          w_we    = cmd_we;
          w_cyc   = 1'b1;
          w_stb   = 1'b1;
          w_cnt   = '0;
          w_state = S_BUS;
        end
      end

      S_BUS: begin
        // err wins over ack when both arrive together.
        if (wb.err || wb.ack) begin
          w_cyc       = 1'b0;
          w_stb       = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_err   = wb.err;
          w_rsp_dat   = (wb.err || r_we) ? '0 : wb.dat_r;
          w_state     = S_RESP;
        end else if (TIMEOUT_EN && (r_cnt == C_LAST)) begin
          w_cyc         = 1'b0;
          w_stb         = 1'b0;
          w_rsp_valid   = 1'b1;
          w_rsp_timeout = 1'b1;
          w_rsp_dat     = '0;
          w_state       = S_RESP;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid   = 1'b0;
          w_rsp_err     = 1'b0;
          w_rsp_timeout = 1'b0;
          w_rsp_dat     = '0;
          w_state       = S_IDLE;
        end
      end

      default: w_state = S_IDLE;
    endcase

    // Registered ready: a command is only taken in the cycle after IDLE is entered.
    w_cmd_ready = (w_state == S_IDLE);
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_dat     = r_rsp_dat;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

  assign wb.adr   = r_adr;
  assign wb.dat_w = r_dat_w;
  assign wb.sel   = r_sel;
  assign wb.we    = r_we;
  assign wb.cyc   = r_cyc;
  assign wb.stb   = r_stb;
  assign wb.cti   = 3'b000;
  assign wb.bte   = 2'b00;

endmodule
